// File: rtl/gemm_unpack_pkg.sv
// rtl/gemm_unpack_pkg.sv - shared types and constants for the GEMM output tile unpacker
package gemm_unpack_pkg;

    // Element and tile geometry; the top-level parameter defaults must match these.
    localparam int ElemWidth      = 32;
    localparam int TileRows       = 4;
    localparam int TileCols       = 16;
    localparam int CoordWidth     = 32;
    localparam int TileSize       = TileRows * TileCols;
    localparam int PackedOutWidth = TileSize * ElemWidth;
    localparam int RowsValidWidth = $clog2(TileRows + 1);
    localparam int ColsValidWidth = $clog2(TileCols + 1);

    // One buffered tile plus everything the pop side needs to walk it.
    typedef struct packed {
        logic [PackedOutWidth-1:0] data;
        logic [CoordWidth-1:0]     tile_m;
        logic [CoordWidth-1:0]     tile_n;
        logic [RowsValidWidth-1:0] rows_valid;
        logic [ColsValidWidth-1:0] cols_valid;
        logic                      is_final;
    } tile_entry_t;

    typedef enum logic {
        IDLE,
        RUN
    } unpack_state_e;

endpackage

// File: rtl/gemm_tile_fifo.sv
// rtl/gemm_tile_fifo.sv - register FIFO of tile entries with head and second-entry peek
module gemm_tile_fifo
    import gemm_unpack_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  tile_entry_t push_entry_i,
    input  logic        pop_i,
    output tile_entry_t head_o,
    output tile_entry_t next_o,
    output logic        full_o,
    output logic        empty_o,
    output logic        multi_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    tile_entry_t     mem [Depth];
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // A push into a full FIFO lands in the slot being vacated by a same-cycle pop.
    assign do_pop  = pop_i && (count != '0);
    assign do_push = push_i && ((count != CntW'(Depth)) || do_pop);

    assign head_o  = mem[rd_ptr];
    assign next_o  = mem[ptr_inc(rd_ptr)];
    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign multi_o = (count > CntW'(1));

    // Entry storage; payload needs no reset because count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gemm_tile_unpacker.sv
// rtl/gemm_tile_unpacker.sv - buffers packed C tiles and streams them as coordinate-tagged elements
module gemm_tile_unpacker
    import gemm_unpack_pkg::*;
#(
    parameter int OutDataWidth  = ElemWidth,
    parameter int RowPar        = TileRows,
    parameter int ColPar        = TileCols,
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = CoordWidth,
    parameter int TileFifoDepth = 2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    start_i,
    input  logic [SizeAddrWidth-1:0]                M_size_i,
    input  logic [SizeAddrWidth-1:0]                N_size_i,
    input  logic                                    tile_we_i,
    input  logic [AddrWidth-1:0]                    tile_addr_i,
    input  logic [RowPar*ColPar*OutDataWidth-1:0]   tile_wdata_i,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [OutDataWidth-1:0]                 out_data_o,
    output logic [SizeAddrWidth-1:0]                out_row_o,
    output logic [SizeAddrWidth-1:0]                out_col_o,
    output logic                                    out_last_o,
    output logic                                    done_o,
    output logic                                    overflow_o,
    output logic                                    order_err_o
);

    localparam logic [SizeAddrWidth-1:0] RowParW = SizeAddrWidth'(RowPar);
    localparam logic [SizeAddrWidth-1:0] ColParW = SizeAddrWidth'(ColPar);

    unpack_state_e              state;
    logic [SizeAddrWidth-1:0]   m_size;
    logic [SizeAddrWidth-1:0]   n_size;
    logic [SizeAddrWidth-1:0]   n_tiles;
    logic [SizeAddrWidth-1:0]   total_tiles;
    logic [SizeAddrWidth-1:0]   tile_m;
    logic [SizeAddrWidth-1:0]   tile_n;
    logic [SizeAddrWidth-1:0]   push_idx;

    logic [SizeAddrWidth-1:0]   m_tiles_in;
    logic [SizeAddrWidth-1:0]   n_tiles_in;
    logic [SizeAddrWidth-1:0]   rows_rem;
    logic [SizeAddrWidth-1:0]   cols_rem;
    logic                       push_in_range;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_multi;
    tile_entry_t                push_entry;
    tile_entry_t                head_entry;
    tile_entry_t                next_entry;

    logic [RowsValidWidth-1:0]  cur_q;
    logic [ColsValidWidth-1:0]  cur_l;
    logic                       cur_entry_last;
    logic                       hs;
    logic                       load;
    logic                       final_hs;
    logic                       nxt_valid;
    logic                       nxt_entry_last;
    logic [RowsValidWidth-1:0]  nxt_q;
    logic [ColsValidWidth-1:0]  nxt_l;
    tile_entry_t                src_entry;

    function automatic logic [OutDataWidth-1:0] elem_of(input tile_entry_t e,
                                                        input logic [RowsValidWidth-1:0] q,
                                                        input logic [ColsValidWidth-1:0] l);
        int idx;
        idx = int'(q) * ColPar + int'(l);
        return e.data[idx*OutDataWidth +: OutDataWidth];
    endfunction

    // Tile grid of the incoming job: ceil(M/RowPar) and ceil(N/ColPar) without overflow on large sizes.
    always_comb begin
        m_tiles_in = (M_size_i / RowParW) + SizeAddrWidth'((M_size_i % RowParW) != '0);
        n_tiles_in = (N_size_i / ColParW) + SizeAddrWidth'((N_size_i % ColParW) != '0);
    end

    // Entry built from the internal push counters; tile_addr_i is only checked, never used.
    always_comb begin
        rows_rem                = m_size - tile_m * RowParW;
        cols_rem                = n_size - tile_n * ColParW;
        push_in_range           = (push_idx < total_tiles);
        push_entry.data         = tile_wdata_i;
        push_entry.tile_m       = tile_m;
        push_entry.tile_n       = tile_n;
        push_entry.rows_valid   = (rows_rem >= RowParW) ? RowsValidWidth'(RowPar)
                                                        : rows_rem[RowsValidWidth-1:0];
        push_entry.cols_valid   = (cols_rem >= ColParW) ? ColsValidWidth'(ColPar)
                                                        : cols_rem[ColsValidWidth-1:0];
        push_entry.is_final     = (push_idx == total_tiles - SizeAddrWidth'(1));
        fifo_push               = (state == RUN) && tile_we_i && push_in_range;
    end

    gemm_tile_fifo #(
        .Depth (TileFifoDepth)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (fifo_push),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .head_o       (head_entry),
        .next_o       (next_entry),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .multi_o      (fifo_multi)
    );

    // Chooses the element to present next: continue the head tile, or jump to the second entry when the head pops.
    always_comb begin
        hs        = out_valid_o && out_ready_i;
        final_hs  = hs && out_last_o;
        fifo_pop  = hs && cur_entry_last;
        load      = !out_valid_o || hs;
        nxt_valid = 1'b0;
        src_entry = head_entry;
        nxt_q     = '0;
        nxt_l     = '0;
        if (!out_valid_o) begin
            nxt_valid = !fifo_empty;
        end else if (hs) begin
            if (!cur_entry_last) begin
                nxt_valid = 1'b1;
                if (cur_l == head_entry.cols_valid - ColsValidWidth'(1)) begin
                    nxt_q = cur_q + RowsValidWidth'(1);
                end else begin
                    nxt_q = cur_q;
                    nxt_l = cur_l + ColsValidWidth'(1);
                end
            end else begin
                nxt_valid = fifo_multi;
                src_entry = next_entry;
            end
        end
        nxt_entry_last = (nxt_q == src_entry.rows_valid - RowsValidWidth'(1)) &&
                         (nxt_l == src_entry.cols_valid - ColsValidWidth'(1));
    end

    // Registered output stage; fields change only on load, so they hold while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o    <= 1'b0;
            out_data_o     <= '0;
            out_row_o      <= '0;
            out_col_o      <= '0;
            out_last_o     <= 1'b0;
            cur_q          <= '0;
            cur_l          <= '0;
            cur_entry_last <= 1'b0;
        end else if (load) begin
            out_valid_o <= nxt_valid;
            out_last_o  <= nxt_valid && nxt_entry_last && src_entry.is_final;
            if (nxt_valid) begin
                out_data_o     <= elem_of(src_entry, nxt_q, nxt_l);
                out_row_o      <= src_entry.tile_m * RowParW + SizeAddrWidth'(nxt_q);
                out_col_o      <= src_entry.tile_n * ColParW + SizeAddrWidth'(nxt_l);
                cur_q          <= nxt_q;
                cur_l          <= nxt_l;
                cur_entry_last <= nxt_entry_last;
            end
        end
    end

    // Job control FSM: size latch, push counters, sticky error flags and the done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            m_size      <= '0;
            n_size      <= '0;
            n_tiles     <= '0;
            total_tiles <= '0;
            tile_m      <= '0;
            tile_n      <= '0;
            push_idx    <= '0;
            done_o      <= 1'b0;
            overflow_o  <= 1'b0;
            order_err_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        m_size      <= M_size_i;
                        n_size      <= N_size_i;
                        n_tiles     <= n_tiles_in;
                        total_tiles <= m_tiles_in * n_tiles_in;
                        tile_m      <= '0;
                        tile_n      <= '0;
                        push_idx    <= '0;
                        overflow_o  <= 1'b0;
                        order_err_o <= 1'b0;
                        if ((M_size_i == '0) || (N_size_i == '0)) begin
                            done_o <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (tile_we_i) begin
                        if (!push_in_range) begin
                            order_err_o <= 1'b1;
                        end else begin
                            if (SizeAddrWidth'(tile_addr_i) != push_idx) order_err_o <= 1'b1;
                            if (fifo_full && !fifo_pop) overflow_o <= 1'b1;
                            push_idx <= push_idx + SizeAddrWidth'(1);
                            if (tile_n == n_tiles - SizeAddrWidth'(1)) begin
                                tile_n <= '0;
                                tile_m <= tile_m + SizeAddrWidth'(1);
                            end else begin
                                tile_n <= tile_n + SizeAddrWidth'(1);
                            end
                        end
                    end
                    if (final_hs) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gemm_tile_unpacker.md
# gemm_tile_unpacker

Downstream stage of `gemm_accelerator_top`. It captures each packed output tile as the accelerator writes it (`sram_c_we_o` / `sram_c_addr_o` / `sram_c_wdata_o`) and buffers it in a small tile FIFO. It then streams the tile out as individual `OutDataWidth` elements with matrix coordinates over a valid/ready interface, dropping padding elements outside M×N. It lets result consumers such as a DMA or checker take C without unpacking a 2048-bit SRAM word.

## Interface
Parameters:
- `OutDataWidth`, 32: element width.
- `RowPar`, 4: tile rows.
- `ColPar`, 16: tile columns.
- `AddrWidth`, 12: tile address width.
- `SizeAddrWidth`, 32: width of the M/N sizes and the coordinates.
- `TileFifoDepth`, 2: tile buffer entries, ≥1.

Ports:
- One clock; reset is asynchronous and active-low (`clk_i`, `rst_ni`).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  latches sizes and starts a job; same cycle as the accelerator's `start_i`.
- `M_size_i`  in  SizeAddrWidth  rows of C.
- `N_size_i`  in  SizeAddrWidth  columns of C.
- `tile_we_i`  in  1  tile write strobe (from `sram_c_we_o`).
- `tile_addr_i`  in  AddrWidth  tile index (from `sram_c_addr_o`).
- `tile_wdata_i`  in  RowPar*ColPar*OutDataWidth  packed tile; element i=q*ColPar+l is at [i*OutDataWidth +: OutDataWidth].
- `out_valid_o`  out  1  element valid.
- `out_ready_i`  in  1  consumer ready.
- `out_data_o`  out  OutDataWidth  element value.
- `out_row_o`  out  SizeAddrWidth  global row.
- `out_col_o`  out  SizeAddrWidth  global column.
- `out_last_o`  out  1  final element of the job.
- `done_o`  out  1  one-cycle pulse at job end.
- `overflow_o`  out  1  sticky; a tile was dropped because the FIFO was full.
- `order_err_o`  out  1  sticky; `tile_addr_i` did not match the expected index.

## Operation
States: IDLE, RUN.

**Job start and tile grid**
- `start_i` is honoured only in IDLE and is ignored in RUN.
- On `start_i` the block latches M and N and computes the tile grid: M_tiles=ceil(M/RowPar), N_tiles=ceil(N/ColPar), Total=M_tiles*N_tiles.
- It clears the push counters (tile_m, tile_n, expected index) and both sticky flags, then enters RUN.
- If M=0 or N=0, the block pulses `done_o` the next cycle, stays in IDLE and emits no elements.

**Push side (RUN only)**
- In IDLE, `tile_we_i` is ignored.
- A tile is pushed when `tile_we_i` is high and the FIFO is not full.
- Each FIFO entry stores: data, tile_m, tile_n, rows_valid=min(RowPar, M−tile_m*RowPar), cols_valid=min(ColPar, N−tile_n*ColPar), and is_final (index = Total−1).
- If the FIFO is full, the tile is dropped, `overflow_o` is set, and the push counters still advance.
- If `tile_addr_i` differs from the expected index, `order_err_o` is set. The tile is still accepted, using the internal coordinates.
- Push counters advance row-major: tile_n increments first and wraps at N_tiles, then tile_m increments.
- Pushes beyond Total are ignored and set `order_err_o`.

**Pop side**
- The block walks q over 0..rows_valid−1 and, within each q, l over 0..cols_valid−1.
- Output fields: `out_row_o`=tile_m*RowPar+q, `out_col_o`=tile_n*ColPar+l, `out_data_o`=element q*ColPar+l.
- Padding elements are never presented, so there are no bubbles.
- The FIFO entry is popped on the handshake of its last valid element.
- `out_last_o` is high with the final element of the entry flagged is_final.
- The handshake of that final element returns the block to IDLE and pulses `done_o` the following cycle.

**Arithmetic**
- Coordinates are computed in SizeAddrWidth bits with unsigned arithmetic.
- rows_valid and cols_valid are $clog2(RowPar+1) and $clog2(ColPar+1) bits wide respectively.

## Timing
- **Reset values:** `out_valid_o`=0, `out_data_o`=0, `out_row_o`=0, `out_col_o`=0, `out_last_o`=0, `done_o`=0, `overflow_o`=0, `order_err_o`=0. The FIFO is empty and the state is IDLE.
- **Latency:** a tile pushed into an empty FIFO at edge t produces `out_valid_o`=1 after edge t+1.
- **Throughput:** one element per cycle while `out_ready_i`=1.
- **Valid/ready rules:** once `out_valid_o` is high, all out_* fields are held stable until the handshake. `out_valid_o` never drops without a handshake.
- **Simultaneous push and pop:**
  - When the last element of an entry is popped in the same cycle as a push into a full FIFO, the push is accepted and there is no overflow.
  - The next entry is presented the following cycle.
- **`done_o`:** asserted exactly one cycle, the cycle after the final handshake.
- **Reset mid-job:** the asynchronous reset clears everything immediately; partial tiles are discarded.

## Structure
- **Package `gemm_unpack_pkg`:**
  - constants TileSize=RowPar*ColPar and PackedOutWidth=TileSize*OutDataWidth;
  - typedef `tile_entry_t` (data, tile_m, tile_n, rows_valid, cols_valid, is_final);
  - state enum `unpack_state_e` {IDLE, RUN}.
- **Sub-module `gemm_tile_fifo`:** a generic register FIFO over `tile_entry_t`, with push/pop/full/empty; it supports a same-cycle push and pop when full.

## Test plan
- M=K=N=32, `out_ready_i`=1, tiles written by the accelerator:
  - 1024 handshakes; tile 0 emits (0,0)…(3,15), then tile 1 emits (0,16)…;
  - values match the golden C; `out_last_o` on (31,31); `done_o` 1 cycle later.
- M=5, N=17 (2×2 tiles):
  - 64+1... element counts are 64, 4, 16, 1, for 85 handshakes in total;
  - no padding coordinate appears; `out_last_o` on (4,16).
- Backpressure: `out_ready_i` random 50%:
  - data, row and col stay stable while stalled;
  - the element sequence is identical to the ready=1 run.
- Overflow: hold `out_ready_i`=0, push 3 tiles with depth 2:
  - `overflow_o`=1 after the third push;
  - only tiles 0 and 1 are emitted; `done_o` never pulses until reset.
- Order and edge cases:
  - tile addresses 0, 3 → `order_err_o`=1, data still emitted with internal coordinates;
  - M=0 → `done_o` one cycle after `start_i`, no `out_valid_o`;
  - `rst_ni` low mid-stream → all outputs 0 within the same cycle.
